// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared XNOR LFSR tap table and width limits
package lfsr_pkg;

    localparam int LFSR_MIN_WID = 3;
    localparam int LFSR_MAX_WID = 32;

    // Maximal-length XNOR taps; tap n (1-based) maps to mask bit n-1.
    function automatic logic [LFSR_MAX_WID-1:0] lfsr_mask(input int wid);
        logic [LFSR_MAX_WID-1:0] m;
        m = '0;
        case (wid)
            3:  begin m[2]  = 1'b1; m[1]  = 1'b1; end
            4:  begin m[3]  = 1'b1; m[2]  = 1'b1; end
            5:  begin m[4]  = 1'b1; m[2]  = 1'b1; end
            6:  begin m[5]  = 1'b1; m[4]  = 1'b1; end
            7:  begin m[6]  = 1'b1; m[5]  = 1'b1; end
            8:  begin m[7]  = 1'b1; m[5]  = 1'b1; m[4] = 1'b1; m[3] = 1'b1; end
            9:  begin m[8]  = 1'b1; m[4]  = 1'b1; end
            10: begin m[9]  = 1'b1; m[6]  = 1'b1; end
            11: begin m[10] = 1'b1; m[8]  = 1'b1; end
            12: begin m[11] = 1'b1; m[5]  = 1'b1; m[3] = 1'b1; m[0] = 1'b1; end
            13: begin m[12] = 1'b1; m[3]  = 1'b1; m[2] = 1'b1; m[0] = 1'b1; end
            14: begin m[13] = 1'b1; m[4]  = 1'b1; m[2] = 1'b1; m[0] = 1'b1; end
            15: begin m[14] = 1'b1; m[13] = 1'b1; end
            16: begin m[15] = 1'b1; m[14] = 1'b1; m[12] = 1'b1; m[3] = 1'b1; end
            17: begin m[16] = 1'b1; m[13] = 1'b1; end
            18: begin m[17] = 1'b1; m[10] = 1'b1; end
            19: begin m[18] = 1'b1; m[5]  = 1'b1; m[1] = 1'b1; m[0] = 1'b1; end
            20: begin m[19] = 1'b1; m[16] = 1'b1; end
            21: begin m[20] = 1'b1; m[18] = 1'b1; end
            22: begin m[21] = 1'b1; m[20] = 1'b1; end
            23: begin m[22] = 1'b1; m[17] = 1'b1; end
            24: begin m[23] = 1'b1; m[22] = 1'b1; m[21] = 1'b1; m[16] = 1'b1; end
            25: begin m[24] = 1'b1; m[21] = 1'b1; end
            26: begin m[25] = 1'b1; m[5]  = 1'b1; m[1] = 1'b1; m[0] = 1'b1; end
            27: begin m[26] = 1'b1; m[4]  = 1'b1; m[1] = 1'b1; m[0] = 1'b1; end
            28: begin m[27] = 1'b1; m[24] = 1'b1; end
            29: begin m[28] = 1'b1; m[26] = 1'b1; end
            30: begin m[29] = 1'b1; m[5]  = 1'b1; m[3] = 1'b1; m[0] = 1'b1; end
            31: begin m[30] = 1'b1; m[27] = 1'b1; end
            32: begin m[31] = 1'b1; m[21] = 1'b1; m[1] = 1'b1; m[0] = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - one combinational XNOR LFSR shift
module lfsr_step #(
    parameter int WID = 27
) (
    input  logic [WID-1:0] state_i,
    input  logic [WID-1:0] mask_i,
    input  logic           cyc_i,
    output logic [WID-1:0] next_o
);

    logic fb;

    always_comb begin
        fb     = ~(^(state_i & mask_i)) ^ cyc_i;
        next_o = {state_i[WID-2:0], fb};
    end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised XNOR LFSR counter with seed load, terminal count and lock-up recovery
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int             WID         = 27,
    parameter int             NSTEP       = 1,
    parameter logic [WID-1:0] RST_VAL     = '0,
    parameter bit             AUTO_RELOAD = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic           cyc,
    input  logic           ld,
    input  logic [WID-1:0] seed,
    input  logic [WID-1:0] term,
    output logic [WID-1:0] o,
    output logic           tc,
    output logic           lockup
);

    if (WID < LFSR_MIN_WID || WID > LFSR_MAX_WID) begin : g_bad_wid
        $fatal(1, "lfsr_gen: WID out of range");
    end
    if (NSTEP < 1 || NSTEP > 8) begin : g_bad_nstep
        $fatal(1, "lfsr_gen: NSTEP out of range");
    end
    if (RST_VAL == {WID{1'b1}}) begin : g_bad_rst
        $fatal(1, "lfsr_gen: RST_VAL must not be all-ones");
    end

    localparam logic [LFSR_MAX_WID-1:0] MASK_FULL = lfsr_mask(WID);
    localparam logic [WID-1:0]          TAP_MASK  = MASK_FULL[WID-1:0];

    logic [WID-1:0] state_q, state_d;
    logic           tc_q, tc_d;
    logic           lockup_q, lockup_d;
    logic [WID-1:0] advance;

    // cyc only perturbs the first shift of each advance.
    for (genvar g = 0; g < NSTEP; g++) begin : g_step
        logic [WID-1:0] cur;
        logic [WID-1:0] nxt;
        if (g == 0) begin : g_head
            assign cur = state_q;
        end else begin : g_link
            assign cur = g_step[g-1].nxt;
        end
        lfsr_step #(.WID(WID)) u_step (
            .state_i (cur),
            .mask_i  (TAP_MASK),
            .cyc_i   ((g == 0) ? cyc : 1'b0),
            .next_o  (nxt)
        );
    end

    assign advance = g_step[NSTEP-1].nxt;

    always_comb begin
        state_d  = state_q;
        tc_d     = 1'b0;
        lockup_d = 1'b0;
        if (ld) begin
            state_d = seed;
        end else if (&state_q) begin
            state_d  = RST_VAL;
            lockup_d = 1'b1;
        end else if (ce) begin
            if (state_q == term) begin
                tc_d    = 1'b1;
                state_d = AUTO_RELOAD ? seed : advance;
            end else begin
                state_d = advance;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_VAL;
            tc_q     <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tc_q     <= tc_d;
            lockup_q <= lockup_d;
        end
    end

    assign o      = state_q;
    assign tc     = tc_q;
    assign lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - self-checking bench for lfsr_gen at three configurations
module tb_lfsr_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // a: WID=4 NSTEP=1 reload; b: WID=4 NSTEP=2 free-run; c: WID=27 NSTEP=1 reload
    logic        ce_a = 0, cyc_a = 0, ld_a = 0, tc_a, lk_a;
    logic [3:0]  seed_a = 0, term_a = 4'hF, o_a;
    logic        ce_b = 0, cyc_b = 0, ld_b = 0, tc_b, lk_b;
    logic [3:0]  seed_b = 0, term_b = 4'hF, o_b;
    logic        ce_c = 0, cyc_c = 0, ld_c = 0, tc_c, lk_c;
    logic [26:0] seed_c = 0, term_c = '1, o_c;

    int n_checks = 0;
    int n_fail = 0;

    lfsr_gen #(.WID(4), .NSTEP(1), .RST_VAL(4'h0), .AUTO_RELOAD(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .ce(ce_a), .cyc(cyc_a), .ld(ld_a),
        .seed(seed_a), .term(term_a), .o(o_a), .tc(tc_a), .lockup(lk_a));
    lfsr_gen #(.WID(4), .NSTEP(2), .RST_VAL(4'h0), .AUTO_RELOAD(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .ce(ce_b), .cyc(cyc_b), .ld(ld_b),
        .seed(seed_b), .term(term_b), .o(o_b), .tc(tc_b), .lockup(lk_b));
    lfsr_gen #(.WID(27), .NSTEP(1), .RST_VAL(27'h0), .AUTO_RELOAD(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .ce(ce_c), .cyc(cyc_c), .ld(ld_c),
        .seed(seed_c), .term(term_c), .o(o_c), .tc(tc_c), .lockup(lk_c));

    // Reference: taps listed as 1-based positions, parity counted bit by bit.
    function automatic logic [31:0] ref_adv(input int wid, input int nstep,
                                            input logic [31:0] s, input bit cyc);
        int taps[4];
        logic [31:0] full;
        logic [31:0] r;
        int cnt;
        bit fb;
        full = (32'd1 << wid) - 32'd1;
        if (wid == 4) taps = '{4, 3, 0, 0};
        else          taps = '{27, 5, 2, 1};
        r = s;
        for (int k = 0; k < nstep; k++) begin
            cnt = 0;
            for (int t = 0; t < 4; t++)
                if (taps[t] != 0) cnt += int'(r[taps[t]-1]);
            fb = ((cnt % 2) == 0) ^ ((k == 0) ? cyc : 1'b0);
            r = ((r << 1) | 32'(fb)) & full;
        end
        return r;
    endfunction

    function automatic void ref_edge(input int wid, input int nstep, input bit ar,
                                     input logic [31:0] s, input bit ld, input bit ce,
                                     input bit cyc, input logic [31:0] seed,
                                     input logic [31:0] term, output logic [31:0] ns,
                                     output bit tc, output bit lk);
        logic [31:0] full;
        full = (32'd1 << wid) - 32'd1;
        ns = s; tc = 0; lk = 0;
        if (ld) ns = seed & full;
        else if (s == full) begin ns = 0; lk = 1; end
        else if (ce) begin
            if (s == (term & full)) begin
                tc = 1;
                ns = ar ? (seed & full) : ref_adv(wid, nstep, s, cyc);
            end else begin
                ns = ref_adv(wid, nstep, s, cyc);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ld_a = 0; ce_a = 0; cyc_a = 0;
        ld_b = 0; ce_b = 0; cyc_b = 0;
        ld_c = 0; ce_c = 0; cyc_c = 0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({o_a, tc_a, lk_a, o_b, tc_b, lk_b} !== 12'h000 || {o_c, tc_c, lk_c} !== 29'h0) begin
            n_fail++;
            $display("FAIL reset_state: a=%h/%b/%b b=%h/%b/%b c=%h/%b/%b required all zero",
                     o_a, tc_a, lk_a, o_b, tc_b, lk_b, o_c, tc_c, lk_c);
        end
        do_reset();
    endtask

    task automatic test_free_run();
        logic [3:0] exp_first[6];
        bit seen_ones;
        exp_first = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD};
        do_reset();
        term_a = 4'hF;
        ce_a = 1;
        seen_ones = 0;
        n_checks++;
        if (o_a !== exp_first[0]) begin
            n_fail++;
            $display("FAIL free_run_start: got %h required %h", o_a, exp_first[0]);
        end
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (o_a === 4'hF) seen_ones = 1;
            if (i < 6) begin
                n_checks++;
                if (o_a !== exp_first[i]) begin
                    n_fail++;
                    $display("FAIL free_run_seq[%0d]: got %h required %h", i, o_a, exp_first[i]);
                end
            end
        end
        n_checks++;
        if (o_a !== 4'h0 || seen_ones) begin
            n_fail++;
            $display("FAIL free_run_period: got %h ones_seen=%0d required 0 and 0", o_a, seen_ones);
        end
        ce_a = 0;
    endtask

    task automatic test_period();
        logic [3:0] exp_o[7];
        bit exp_tc[7];
        exp_o  = '{4'h3, 4'h7, 4'h1, 4'h3, 4'h7, 4'h1, 4'h3};
        exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        seed_a = 4'h1; term_a = 4'h7; ld_a = 1;
        tick();
        ld_a = 0; ce_a = 1;
        n_checks++;
        if (o_a !== 4'h1 || tc_a !== 1'b0 || lk_a !== 1'b0) begin
            n_fail++;
            $display("FAIL period_load: got %h/%b/%b required 1/0/0", o_a, tc_a, lk_a);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (o_a !== exp_o[i] || tc_a !== exp_tc[i]) begin
                n_fail++;
                $display("FAIL period[%0d]: got o=%h tc=%b required o=%h tc=%b",
                         i, o_a, tc_a, exp_o[i], exp_tc[i]);
            end
        end
        ce_a = 0;
    endtask

    task automatic test_lockup();
        seed_a = 4'hF; ld_a = 1; ce_a = 0;
        tick();
        ld_a = 0;
        n_checks++;
        if (o_a !== 4'hF || lk_a !== 1'b0) begin
            n_fail++;
            $display("FAIL lockup_load: got o=%h lockup=%b required F/0", o_a, lk_a);
        end
        tick();
        n_checks++;
        if (o_a !== 4'h0 || lk_a !== 1'b1 || tc_a !== 1'b0) begin
            n_fail++;
            $display("FAIL lockup_recover: got o=%h lockup=%b tc=%b required 0/1/0", o_a, lk_a, tc_a);
        end
        tick();
        n_checks++;
        if (o_a !== 4'h0 || lk_a !== 1'b0) begin
            n_fail++;
            $display("FAIL lockup_pulse: got o=%h lockup=%b required 0/0", o_a, lk_a);
        end
    endtask

    task automatic test_nstep2();
        do_reset();
        term_b = 4'hF; ce_b = 1;
        tick();
        n_checks++;
        if (o_b !== 4'h3) begin
            n_fail++;
            $display("FAIL nstep2_first: got %h required 3", o_b);
        end
        tick();
        ce_b = 0;
        n_checks++;
        if (o_b !== 4'hE) begin
            n_fail++;
            $display("FAIL nstep2_second: got %h required e", o_b);
        end
    endtask

    task automatic test_cyc27();
        do_reset();
        term_c = '1; ce_c = 1; cyc_c = 1;
        tick();
        cyc_c = 0;
        n_checks++;
        if (o_c !== 27'h0) begin
            n_fail++;
            $display("FAIL cyc27_shorten: got %h required 0", o_c);
        end
        tick();
        ce_c = 0;
        n_checks++;
        if (o_c !== 27'h1) begin
            n_fail++;
            $display("FAIL cyc27_normal: got %h required 1", o_c);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        seed_a = 4'h1; term_a = 4'h3; ld_a = 1;
        tick();
        ld_a = 0; ce_a = 1;
        tick();
        tick();
        n_checks++;
        if (o_a !== 4'h1 || tc_a !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: got o=%h tc=%b required 1/1", o_a, tc_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_a !== 4'h0 || tc_a !== 1'b0 || lk_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_assert: got %h/%b/%b required 0/0/0", o_a, tc_a, lk_a);
        end
        tick();
        n_checks++;
        if (o_a !== 4'h0 || tc_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_hold: got o=%h tc=%b required 0/0", o_a, tc_a);
        end
        rst_n = 1'b1;
        term_a = 4'hF;
        tick();
        ce_a = 0;
        n_checks++;
        if (o_a !== 4'h1) begin
            n_fail++;
            $display("FAIL async_resume: got %h required 1", o_a);
        end
    endtask

    task automatic test_random();
        logic [31:0] ms_a, ms_b, ms_c, ns;
        bit etc, elk;
        bit etc_b, elk_b, etc_c, elk_c;
        logic [31:0] ns_b, ns_c;
        do_reset();
        ms_a = 0; ms_b = 0; ms_c = 0;
        for (int i = 0; i < 400; i++) begin
            ld_a = ($urandom % 8) == 0; ce_a = ($urandom % 4) != 0; cyc_a = ($urandom % 6) == 0;
            seed_a = (($urandom % 8) == 0) ? 4'hF : 4'($urandom);
            term_a = (($urandom % 2) == 0) ? ms_a[3:0] : 4'($urandom);
            ld_b = ($urandom % 8) == 0; ce_b = ($urandom % 4) != 0; cyc_b = ($urandom % 6) == 0;
            seed_b = (($urandom % 8) == 0) ? 4'hF : 4'($urandom);
            term_b = (($urandom % 2) == 0) ? ms_b[3:0] : 4'($urandom);
            ld_c = ($urandom % 8) == 0; ce_c = ($urandom % 4) != 0; cyc_c = ($urandom % 6) == 0;
            seed_c = (($urandom % 8) == 0) ? '1 : 27'($urandom);
            term_c = (($urandom % 2) == 0) ? ms_c[26:0] : 27'($urandom);
            ref_edge(4, 1, 1'b1, ms_a, ld_a, ce_a, cyc_a, 32'(seed_a), 32'(term_a), ns, etc, elk);
            ref_edge(4, 2, 1'b0, ms_b, ld_b, ce_b, cyc_b, 32'(seed_b), 32'(term_b), ns_b, etc_b, elk_b);
            ref_edge(27, 1, 1'b1, ms_c, ld_c, ce_c, cyc_c, 32'(seed_c), 32'(term_c), ns_c, etc_c, elk_c);
            tick();
            ms_a = ns; ms_b = ns_b; ms_c = ns_c;
            n_checks++;
            if (o_a !== ms_a[3:0] || tc_a !== etc || lk_a !== elk) begin
                n_fail++;
                $display("FAIL random_a[%0d]: got %h/%b/%b required %h/%b/%b",
                         i, o_a, tc_a, lk_a, ms_a[3:0], etc, elk);
            end
            n_checks++;
            if (o_b !== ms_b[3:0] || tc_b !== etc_b || lk_b !== elk_b) begin
                n_fail++;
                $display("FAIL random_b[%0d]: got %h/%b/%b required %h/%b/%b",
                         i, o_b, tc_b, lk_b, ms_b[3:0], etc_b, elk_b);
            end
            n_checks++;
            if (o_c !== ms_c[26:0] || tc_c !== etc_c || lk_c !== elk_c) begin
                n_fail++;
                $display("FAIL random_c[%0d]: got %h/%b/%b required %h/%b/%b",
                         i, o_c, tc_c, lk_c, ms_c[26:0], etc_c, elk_c);
            end
        end
        ld_a = 0; ce_a = 0; ld_b = 0; ce_b = 0; ld_c = 0; ce_c = 0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_period();
        test_lockup();
        test_nstep2();
        test_cyc27();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
